// File: rtl/mem_pkg.sv
// Shared helpers for the byte-enabled SDP RAM: lane-wise merge of a new word into an old word.
// Used by the RAM's write-first bypass path (SDP_BYPASS_EN) and by the verification model.
package mem_pkg;

  localparam int unsigned MAX_DW = 1024;
  localparam int unsigned MAX_NB = 1024;

  // Bits whose lane (bit / bw) is enabled take new_w; all others keep old_w.
  function automatic logic [MAX_DW-1:0] be_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_NB-1:0] be,
    input int unsigned       bw = 8
  );
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int unsigned i = 0; i < MAX_DW; i++) begin
      if (be[i / bw]) res[i] = new_w[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/sdp_rd_pipe.sv
// Read-result register chain: STAGES data+valid stages with asynchronous active-low reset.
// Data stages load only alongside a valid, so the output holds its last result between reads.
module sdp_rd_pipe #(
  parameter int DW     = 64,
  parameter int STAGES = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic [DW-1:0]     r_data [STAGES];
  logic [STAGES-1:0] r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int s = 0; s < STAGES; s++) r_data[s] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      if (i_valid) r_data[0] <= i_data;
      for (int s = 1; s < STAGES; s++) begin
        r_valid[s] <= r_valid[s-1];
        if (r_valid[s-1]) r_data[s] <= r_data[s-1];
      end
    end
  end

  assign o_valid = r_valid[STAGES-1];
  assign o_data  = r_data[STAGES-1];

endmodule

// File: rtl/sdp_bram_be.sv
// Simple dual-port RAM with per-byte write enables and a 1- or 2-cycle registered read.
// Macro SDP_BYPASS_EN selects write-first on a same-address collision; read-first otherwise.
module sdp_bram_be
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64,
  parameter int BYTE_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          wa,
  input  logic                           we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]          wd,
  input  logic [ADDR_WIDTH-1:0]          ra,
  input  logic                           re,
  output logic [DATA_WIDTH-1:0]          rd,
  output logic                           rvalid
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_err_bw
    $error("sdp_bram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_err_lat
    $error("sdp_bram_be: RD_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH > MAX_DW) begin : g_err_dw
    $error("sdp_bram_be: DATA_WIDTH exceeds mem_pkg::MAX_DW");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // Writes are gated off while reset is held; the array itself is never reset.
  assign w_wr_en = we & rst_n;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (w_wr_en && wbe[i]) r_mem[wa][i*BYTE_WIDTH +: BYTE_WIDTH] <= wd[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

`ifdef SDP_BYPASS_EN
  logic w_collide;
  assign w_collide = w_wr_en && re && (wa == ra);
  assign w_rd_word = w_collide
    ? DATA_WIDTH'(be_merge(MAX_DW'(r_mem[ra]), MAX_DW'(wd), MAX_NB'(wbe), BYTE_WIDTH))
    : r_mem[ra];
`else
  assign w_rd_word = r_mem[ra];
`endif

  sdp_rd_pipe #(
    .DW     (DATA_WIDTH),
    .STAGES (RD_LATENCY)
  ) u_rd_pipe (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (re),
    .i_data  (w_rd_word),
    .o_valid (rvalid),
    .o_data  (rd)
  );

endmodule

// File: tb/tb_sdp_bram_be.sv
// Self-checking bench for sdp_bram_be: one instance per read latency, shared stimulus,
// cycle-level reference model (word array + issued-read history) plus directed corner cases.
module tb_sdp_bram_be;

  localparam int AW = 6;
  localparam int DW = 64;
  localparam int NB = 8;
  localparam int HMAX = 4096;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] wa, ra;
  logic          we, re;
  logic [NB-1:0] wbe;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd1, rd2;
  logic          rvalid1, rvalid2;

  sdp_bram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wa(wa), .we(we), .wbe(wbe), .wd(wd),
    .ra(ra), .re(re), .rd(rd1), .rvalid(rvalid1)
  );

  sdp_bram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wa(wa), .we(we), .wbe(wbe), .wd(wd),
    .ra(ra), .re(re), .rd(rd2), .rvalid(rvalid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] mem_m [1 << AW];
  logic          hv [HMAX];
  logic [DW-1:0] hd [HMAX];
  int            cyc = 0;
  logic [DW-1:0] exp_rd1 = '0, exp_rd2 = '0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int l = 0; l < NB; l++) if (be[l]) r[l*8 +: 8] = n[l*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < HMAX; i++) hv[i] = 1'b0;
    exp_rd1 = '0;
    exp_rd2 = '0;
  endtask

  // One clock: model the issuing edge, then compare both instances #1 after it.
  task automatic tick();
    logic [DW-1:0] iss;
    logic          v1, v2;
    iss = mem_m[ra];
`ifdef SDP_BYPASS_EN
    if (rst_n && we && re && (wa == ra)) iss = merge(iss, wd, wbe);
`endif
    @(posedge clk);
    if (rst_n && we) mem_m[wa] = merge(mem_m[wa], wd, wbe);
    hv[cyc] = re && rst_n;
    hd[cyc] = iss;
    #1;
    v1 = hv[cyc];
    v2 = (cyc >= 1) ? hv[cyc-1] : 1'b0;
    if (v1) exp_rd1 = hd[cyc];
    if (v2) exp_rd2 = hd[cyc-1];
    chk("rvalid_l1", 64'(rvalid1), 64'(v1));
    chk("rd_l1", rd1, exp_rd1);
    chk("rvalid_l2", 64'(rvalid2), 64'(v2));
    chk("rd_l2", rd2, exp_rd2);
    cyc++;
  endtask

  typedef struct {
    logic [AW-1:0] wa;
    logic [NB-1:0] wbe;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tv [6];
  logic [DW-1:0] exp_col;
  int vcount;

  initial begin
    tv[0] = '{6'd5,  8'hFF, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444};
    tv[1] = '{6'd5,  8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 64'h1111_2222_AAAA_AAAA};
    tv[2] = '{6'd5,  8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_2222_AAAA_AAAA};
    tv[3] = '{6'd5,  8'h80, 64'h7777_7777_7777_7777, 64'h7711_2222_AAAA_AAAA};
    tv[4] = '{6'd63, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D};
    tv[5] = '{6'd0,  8'hF0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_0000_0000};

    rst_n = 1'b0; we = 1'b0; re = 1'b0; wa = '0; ra = '0; wbe = '0; wd = '0;
    model_reset();
    #2;
    chk("reset_rd_l1", rd1, 64'h0);
    chk("reset_rvalid_l2", 64'(rvalid2), 64'h0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Initialise every word so later reads are fully defined.
    for (int a = 0; a < (1 << AW); a++) begin
      we = 1'b1; wa = AW'(a); wbe = 8'hFF; wd = '0;
      tick();
    end
    we = 1'b0;

    // Reset blocks writes: attempt to write addr 3 while held in reset.
    #2 rst_n = 1'b0;
    model_reset();
    we = 1'b1; wa = 6'd3; wbe = 8'hFF; wd = '1;
    repeat (3) tick();
    chk("rst_hold_rd_l1", rd1, 64'h0);
    chk("rst_hold_rvalid_l1", 64'(rvalid1), 64'h0);
    we = 1'b0;
    rst_n = 1'b1;
    re = 1'b1; ra = 6'd3;
    tick();
    chk("rst_nowrite_addr3", rd1, 64'h0);
    re = 1'b0;
    repeat (2) tick();

    // Table of write-then-read vectors covering lane merges, no-op, and full depth.
    for (int k = 0; k < 6; k++) begin
      we = 1'b1; wa = tv[k].wa; wbe = tv[k].wbe; wd = tv[k].wd; re = 1'b0;
      tick();
      we = 1'b0; re = 1'b1; ra = tv[k].wa;
      tick();
      chk($sformatf("vec%0d_l1", k), rd1, tv[k].exp);
      re = 1'b0;
      tick();
      chk($sformatf("vec%0d_l2", k), rd2, tv[k].exp);
    end

    // Latency-2 single pulse: valid exactly two edges after... only in the E+1 window.
    repeat (2) tick();
    re = 1'b1; ra = 6'd5;
    tick();
    chk("lat2_pulse_e", 64'(rvalid2), 64'h0);
    re = 1'b0;
    tick();
    chk("lat2_pulse_e1_v", 64'(rvalid2), 64'h1);
    chk("lat2_pulse_e1_d", rd2, 64'h7711_2222_AAAA_AAAA);
    tick();
    chk("lat2_pulse_e2", 64'(rvalid2), 64'h0);

    // Streaming: 8 back-to-back reads give 8 valid results.
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      re = (i < 8); ra = AW'(i);
      tick();
      if (rvalid2) vcount++;
    end
    re = 1'b0;
    tick();
    if (rvalid2) vcount++;
    chk("stream_count", 64'(vcount), 64'd8);

    // Same-cycle collision on addr 7.
    we = 1'b1; wa = 6'd7; wbe = 8'hFF; wd = '0;
    tick();
    wd = 64'h5555_5555_5555_5555; re = 1'b1; ra = 6'd7;
`ifdef SDP_BYPASS_EN
    exp_col = 64'h5555_5555_5555_5555;
`else
    exp_col = 64'h0;
`endif
    tick();
    chk("collide_l1", rd1, exp_col);
    we = 1'b0; re = 1'b0;
    tick();
    chk("collide_l2", rd2, exp_col);

    // In-flight read is not disturbed by a later write; rd holds afterwards.
    we = 1'b1; wa = 6'd2; wbe = 8'hFF; wd = 64'hBEEF;
    tick();
    we = 1'b0; re = 1'b1; ra = 6'd2;
    tick();
    chk("hold_l1_d", rd1, 64'hBEEF);
    re = 1'b0; we = 1'b1; wa = 6'd2; wd = 64'h1234;
    tick();
    we = 1'b0;
    chk("hold_l1_after", rd1, 64'hBEEF);
    chk("hold_l1_v", 64'(rvalid1), 64'h0);
    chk("hold_l2_d", rd2, 64'hBEEF);
    tick();
    chk("hold_l2_after", rd2, 64'hBEEF);
    chk("hold_l2_v", 64'(rvalid2), 64'h0);

    // Mid-pipeline reset drops the latency-2 read; write at the release edge lands.
    re = 1'b1; ra = 6'd5;
    tick();
    re = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_v_l2", 64'(rvalid2), 64'h0);
    chk("midrst_d_l2", rd2, 64'h0);
    we = 1'b1; wa = 6'd4; wbe = 8'hFF; wd = 64'hDEAD;
    tick();
    chk("midrst_nov_l2", 64'(rvalid2), 64'h0);
    wd = 64'h0F0F_0F0F;
    rst_n = 1'b1;
    tick();
    we = 1'b0; re = 1'b1; ra = 6'd4;
    tick();
    chk("release_write", rd1, 64'h0F0F_0F0F);
    re = 1'b0;
    tick();

    // Randomised traffic, addresses clustered for frequent collisions.
    for (int i = 0; i < 400; i++) begin
      we  = 1'($urandom_range(0, 1));
      re  = 1'($urandom_range(0, 1));
      wbe = 8'($urandom);
      wd  = {$urandom(), $urandom()};
      if (i % 4 == 0) begin
        wa = AW'($urandom); ra = AW'($urandom);
      end else begin
        wa = AW'($urandom_range(0, 7)); ra = AW'($urandom_range(0, 7));
      end
      tick();
    end
    we = 1'b0; re = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
